// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_DATA,
    ST_STREAM,
    ST_IGNORE
  } state_e;

  localparam int          CMD_WIDTH   = 8;
  localparam int          CMD_WR_BIT  = 7;
  localparam logic [6:0]  STREAM_ADDR = 7'h7F;

endpackage

// File: rtl/spi_reg_frontend.sv
// Pin conditioning for the SPI slave: synchronises SCLK/MOSI/CS and detects SCLK edges.
module spi_reg_frontend (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_sclk_i,
  input  logic spi_mosi_i,
  input  logic spi_cs_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic mosi_sync_o,
  output logic cs_sync_o
);

  logic sclk_sync;
  logic sclk_dly_q;

  synchronizer #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .d_i(spi_sclk_i), .q_o(sclk_sync)
  );

  synchronizer #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .d_i(spi_mosi_i), .q_o(mosi_sync_o)
  );

  // CS resets to the inactive (high) level so a reset never looks like a select.
  synchronizer #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .d_i(spi_cs_i), .q_o(cs_sync_o)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sclk_dly_q <= 1'b0;
    else          sclk_dly_q <= sclk_sync;
  end

  assign sclk_rise_o =  sclk_sync & ~sclk_dly_q;
  assign sclk_fall_o = ~sclk_sync &  sclk_dly_q;

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset level.
module synchronizer #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave register file with burst auto-increment and a bit-serial stream address.
// Optional MISO readback is enabled by defining SPI_REG_READBACK_EN.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int                              NUM_REGS     = 8,
  parameter int                              REG_WIDTH    = 8,
  parameter logic [NUM_REGS*REG_WIDTH-1:0]   RESET_VALUES = '0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            spi_sclk,
  input  logic                            spi_mosi,
  input  logic                            spi_cs,
  output logic                            spi_miso,
  input  logic                            stream_in,
  output logic                            stream_valid,
  output logic                            stream_bit,
  output logic [NUM_REGS*REG_WIDTH-1:0]   regs,
  output logic [NUM_REGS-1:0]             reg_wr_strobe,
  output logic                            busy
);

  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic sclk_rise;
  logic sclk_fall;
  logic mosi_sync;
  logic cs_sync;

  spi_reg_frontend u_frontend (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_sclk_i  (spi_sclk),
    .spi_mosi_i  (spi_mosi),
    .spi_cs_i    (spi_cs),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .mosi_sync_o (mosi_sync),
    .cs_sync_o   (cs_sync)
  );

  state_e                 state_q;
  logic [4:0]             bitcnt_q;
  logic [CMD_WIDTH-1:0]   cmd_q;
  logic [IDXW-1:0]        addr_q;
  logic                   wr_q;
  logic [REG_WIDTH-1:0]   shadow_q;
  logic [REG_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]    strobe_q;
  logic                   stream_valid_q;
  logic                   stream_bit_q;
  logic                   busy_q;

  logic [CMD_WIDTH-1:0]   cmd_d;
  logic [REG_WIDTH-1:0]   shadow_d;

  always_comb begin
    cmd_d    = {cmd_q[CMD_WIDTH-2:0], mosi_sync};
    shadow_d = (shadow_q << 1) | REG_WIDTH'(mosi_sync);
  end

`ifdef SPI_REG_READBACK_EN
  logic                   miso_q;
  logic [REG_WIDTH-1:0]   rd_shift;

  // Shifting the addressed word left by the bit count puts the next bit at the MSB.
  always_comb begin
    rd_shift = regs_q[addr_q] << bitcnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_q <= 1'b0;
    end else if (cs_sync) begin
      miso_q <= 1'b0;
    end else if (sclk_rise) begin
      case (state_q)
        ST_DATA:   miso_q <= rd_shift[REG_WIDTH-1];
        ST_STREAM: miso_q <= stream_in;
        default:   miso_q <= 1'b0;
      endcase
    end
  end

  assign spi_miso = miso_q;
`else
  logic unused_stream_in;
  assign unused_stream_in = stream_in;
  assign spi_miso         = 1'b0;
`endif

  // Main transfer FSM: CS high always wins, so a partial word can never commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_CMD;
      bitcnt_q       <= '0;
      cmd_q          <= '0;
      addr_q         <= '0;
      wr_q           <= 1'b0;
      shadow_q       <= '0;
      strobe_q       <= '0;
      stream_valid_q <= 1'b0;
      stream_bit_q   <= 1'b0;
      busy_q         <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUES[i*REG_WIDTH +: REG_WIDTH];
      end
    end else begin
      strobe_q       <= '0;
      stream_valid_q <= 1'b0;
      busy_q         <= ~cs_sync;
      if (cs_sync) begin
        state_q  <= ST_CMD;
        bitcnt_q <= '0;
        shadow_q <= '0;
      end else if (sclk_fall) begin
        case (state_q)
          ST_CMD: begin
            if (bitcnt_q == 5'(CMD_WIDTH-1)) begin
              bitcnt_q <= '0;
              wr_q     <= cmd_d[CMD_WR_BIT];
              addr_q   <= cmd_d[IDXW-1:0];
              shadow_q <= '0;
              if (cmd_d[6:0] < 7'(NUM_REGS))        state_q <= ST_DATA;
              else if (cmd_d[6:0] == STREAM_ADDR)   state_q <= ST_STREAM;
              else                                  state_q <= ST_IGNORE;
            end else begin
              bitcnt_q <= bitcnt_q + 5'd1;
            end
            cmd_q <= cmd_d;
          end
          ST_DATA: begin
            if (bitcnt_q == 5'(REG_WIDTH-1)) begin
              bitcnt_q <= '0;
              shadow_q <= '0;
              if (wr_q) begin
                regs_q[addr_q]   <= shadow_d;
                strobe_q[addr_q] <= 1'b1;
              end
              addr_q <= (addr_q == IDXW'(NUM_REGS-1)) ? '0 : addr_q + 1'b1;
            end else begin
              bitcnt_q <= bitcnt_q + 5'd1;
              shadow_q <= shadow_d;
            end
          end
          ST_STREAM: begin
            stream_valid_q <= 1'b1;
            stream_bit_q   <= mosi_sync;
          end
          default: begin
            bitcnt_q <= bitcnt_q + 5'd1;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*REG_WIDTH +: REG_WIDTH] = regs_q[g];
  end

  assign reg_wr_strobe = strobe_q;
  assign stream_valid  = stream_valid_q;
  assign stream_bit    = stream_bit_q;
  assign busy          = busy_q;

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI slave register file and the successor to the fixed five-register sprite SPI receiver. It decodes a command byte holding a R/W flag and a 7-bit address, then transfers bursts of `REG_WIDTH`-bit words with address auto-increment. Writes commit atomically per word, with a one-cycle strobe, and registers can be read back. A reserved stream address gives unbounded bit-serial access, such as sprite bitmap loading. It sits between the chip SPI pins and the video core's configuration inputs.

## Interface
- `NUM_REGS`, 8: number of registers; legal range 1..127.
- `REG_WIDTH`, 8: bits per register; legal range 1..16.
- `RESET_VALUES`, '0: flat `NUM_REGS*REG_WIDTH` vector; register i takes slice i.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `spi_sclk`, `spi_mosi`, `spi_cs` in 1 each: raw asynchronous pins; `spi_cs` is active low.
- `spi_miso` out 1: read data.
- `stream_in` in 1: bit returned on `spi_miso` while in stream mode.
- `stream_valid` out 1: one-clk pulse per streamed bit.
- `stream_bit` out 1: streamed bit; valid only with `stream_valid`.
- `regs` out `NUM_REGS*REG_WIDTH`: register contents, flat bus; register i is slice i.
- `reg_wr_strobe` out `NUM_REGS`: one-clk pulse on the cycle register i is updated.
- `busy` out 1: synchronised CS is active.

## Operation
- All three SPI pins pass through 2-FF synchronisers; SCLK edges are detected against a 1-FF delayed copy.
- MOSI is sampled on detected SCLK falling edges. MISO updates on detected rising edges.
- Command byte is MSB first: bit7 is the write flag (1 = write), bits6:0 are the address. Address 0x7F is `STREAM_ADDR`.
- States:
  - CMD: collects 8 bits, then branches:
    - address < `NUM_REGS` → DATA;
    - address == 0x7F → STREAM;
    - otherwise → IGNORE.
  - DATA: shifts `REG_WIDTH` bits MSB first into a shadow register.
    - On the last bit of a write, `regs[addr]` is loaded from the shadow and `reg_wr_strobe[addr]` pulses.
    - Reads shift but never commit.
    - After each word, the address increments, wrapping from `NUM_REGS-1` to 0; the state stays DATA.
  - STREAM: each falling edge drives `stream_valid`=1 with `stream_bit`=MOSI. No word boundary applies and the state stays STREAM.
  - IGNORE: counts edges only; no side effects, `spi_miso`=0.
- Synchronised CS high, in any state:
  - state → CMD, bit counter → 0, shadow discarded;
  - a partial word never commits.
- CS low→high→low between words is a legal way to start a new command.
- Reset values:
  - `regs` = `RESET_VALUES`;
  - `spi_miso`, `stream_valid`, `stream_bit`, `reg_wr_strobe`, `busy` = 0;
  - state CMD.
- Reset mid-transfer aborts the transfer with no commit.

## Timing
- Pin-to-detected-edge latency is 3 clk. SCLK high and low phases must each be ≥ 4 clk; CS setup to the first SCLK edge must be ≥ 4 clk.
- The commit of `regs` and the `reg_wr_strobe` pulse are registered outputs, asserted the clk after the falling edge of the last data bit is detected.
- `stream_valid` is registered and pulses 1 clk after falling-edge detection.
- A simultaneous CS deassert and last-bit edge in the same clk resolves as CS wins: no commit.

## Configuration
- `SPI_REG_READBACK_EN` defined:
  - in DATA, each rising edge drives `spi_miso` = `regs[addr][REG_WIDTH-1-bitcnt]`, the pre-write value;
  - in STREAM, `spi_miso` = `stream_in`.
- Undefined: `spi_miso` is tied to 0, and the readback mux and `stream_in` path are removed.

## Structure
- Package `spi_reg_pkg` holds:
  - the state enum (CMD, DATA, STREAM, IGNORE);
  - `CMD_WIDTH`=8, `CMD_WR_BIT`=7, `STREAM_ADDR`=7'h7F.
- Sub-module `spi_reg_frontend`: instantiates the existing `synchronizer` three times and outputs `sclk_rise`, `sclk_fall`, `mosi_sync`, `cs_sync`.

## Test plan
- Write 0x85, data 0xA5 → `regs[5]`=0xA5; `reg_wr_strobe[5]` pulses exactly once; other registers unchanged.
- Write 0x86, data 0x11 0x22 0x33, with `NUM_REGS`=8 → `regs[6]`=0x11, `regs[7]`=0x22, `regs[0]`=0x33 (wrap).
- Read 0x05 after the first test, with readback on → MISO returns 0xA5 and `regs` is unchanged; with readback off, MISO stays 0 throughout.
- Write 0xFF, then 100 stream bits, then CS high → exactly 100 `stream_valid` pulses with matching bits; the next command decodes correctly.
- Write 0x83 then CS high after 4 data bits → no strobe, `regs[3]` keeps its reset value; address 0x20 with `NUM_REGS`=8 → no strobe and MISO stays 0.
- Assert `reset_n` mid-word → `regs` return to `RESET_VALUES` and the next transaction starts in CMD.
